rsa_modexp_engine: RTL and testbench

Sequential modular-exponentiation engine computing result = base^exponent mod modulus for the RSA datapath. It is the controlling end of the multiply-and-feedback loop: it issues each product, reduces it modulo n with a shift-subtract reducer, and feeds the remainder back as the next operand. It iterates over a decrementing exponent counter until the count is exhausted, then raises `valid`. The same block serves encryption (exponent = e) and decryption (exponent = d).

---
 rtl/rsa_modexp_engine_if.sv | 24 ++
 rtl/rsa_modexp_engine.sv | 190 +++++++++++++++++++
 tb/tb_rsa_modexp_engine.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_engine_if.sv
// Request/response bundle for rsa_modexp_engine.
// master drives the request side, slave is the engine.
interface rsa_modexp_engine_if #(
  parameter int unsigned WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] exponent;
  logic [WIDTH-1:0] modulus;
  logic             busy;
  logic             valid;
  logic             error;
  logic [WIDTH-1:0] result;

  modport master (
    output start, base, exponent, modulus,
    input  busy, valid, error, result
  );

  modport slave (
    input  start, base, exponent, modulus,
    output busy, valid, error, result
  );
endinterface

// File: rtl/rsa_modexp_engine.sv
// Sequential modular exponentiation: result = base^exponent mod modulus.
// One multiply per MULT cycle, then a restoring shift-subtract reduction over
// WIDTH cycles. The reduction remainder is fed back as the next operand.
// Optional feature macro: RSA_MODEXP_SQMUL_EN selects left-to-right binary
// square-and-multiply; otherwise the exponent is consumed by repeated multiplication.
module rsa_modexp_engine #(
  parameter int unsigned WIDTH = 6
) (
  input logic                clk,
  input logic                rst,
  rsa_modexp_engine_if.slave bus
);
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW = 2 * WIDTH + 1;

  typedef enum logic [2:0] {StIdle, StRedb, StMult, StRed, StDone} state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] base_r_q, base_r_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [RW-1:0]    r_q, r_d;
`ifdef RSA_MODEXP_SQMUL_EN
  logic [WIDTH-1:0] exp_q, exp_d;  // remaining exponent bits, MSB is the current bit
  logic             sq_q, sq_d;    // 1: squaring step, 0: multiply-by-base step
`endif

  logic [RW-1:0]      n_sh;
  logic [RW-1:0]      r_next;
  logic [WIDTH-1:0]   mul_op;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   acc_init;

  // One restoring reduction step plus the shared multiplier.
  always_comb begin
    n_sh     = {{(WIDTH + 1){1'b0}}, n_q} << bit_q;
    r_next   = (r_q >= n_sh) ? (r_q - n_sh) : r_q;
`ifdef RSA_MODEXP_SQMUL_EN
    mul_op   = sq_q ? acc_q : base_r_q;
`else
    mul_op   = base_r_q;
`endif
    prod     = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, mul_op};
    acc_init = {{(WIDTH - 1){1'b0}}, (n_q != WIDTH'(1))};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    error_d  = error_q;
    result_d = result_q;
    n_d      = n_q;
    base_r_d = base_r_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    r_d      = r_q;
`ifdef RSA_MODEXP_SQMUL_EN
    exp_d    = exp_q;
    sq_d     = sq_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          valid_d = 1'b0;
          error_d = 1'b0;
          n_d     = bus.modulus;
          r_d     = {{(WIDTH + 1){1'b0}}, bus.base};
          bit_d   = BW'(WIDTH - 1);
          acc_d   = '0;
`ifdef RSA_MODEXP_SQMUL_EN
          exp_d   = bus.exponent;
          cnt_d   = WIDTH'(WIDTH);
`else
          cnt_d   = bus.exponent;
`endif
          if (bus.modulus == '0) begin
            state_d = StDone;
          end else begin
            busy_d  = 1'b1;
            state_d = StRedb;
          end
        end
      end
      StRedb: begin
        r_d   = r_next;
        bit_d = bit_q - 1'b1;
        if (bit_q == '0) begin
          base_r_d = r_next[WIDTH-1:0];
          acc_d    = acc_init;
`ifdef RSA_MODEXP_SQMUL_EN
          sq_d     = 1'b1;
          state_d  = StMult;
`else
          state_d  = (cnt_q != '0) ? StMult : StDone;
`endif
        end
      end
      StMult: begin
        r_d     = {1'b0, prod};
        bit_d   = BW'(WIDTH - 1);
        state_d = StRed;
      end
      StRed: begin
        r_d   = r_next;
        bit_d = bit_q - 1'b1;
        if (bit_q == '0) begin
          acc_d = r_next[WIDTH-1:0];
`ifdef RSA_MODEXP_SQMUL_EN
          if (sq_q && exp_q[WIDTH-1]) begin
            sq_d    = 1'b0;
            state_d = StMult;
          end else begin
            sq_d    = 1'b1;
            exp_d   = exp_q << 1;
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q != WIDTH'(1)) ? StMult : StDone;
          end
`else
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q != WIDTH'(1)) ? StMult : StDone;
`endif
        end
      end
      StDone: begin
        result_d = acc_q;
        error_d  = (n_q == '0);
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      n_q      <= '0;
      base_r_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      r_q      <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      result_q <= result_d;
      n_q      <= n_d;
      base_r_q <= base_r_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      r_q      <= r_d;
    end
  end

`ifdef RSA_MODEXP_SQMUL_EN
  // Exponent bit scanner for square-and-multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      exp_q <= exp_d;
      sq_q  <= sq_d;
    end
  end
`endif

  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.error  = error_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed scoreboard bench for rsa_modexp_engine.
module tb_rsa_modexp_engine;
  localparam int W = 6;
  localparam int PERIOD = 10;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    logic         bsy;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  time  k_time;
  logic busy_k;

  rsa_modexp_engine_if #(.WIDTH(W)) bus ();

  rsa_modexp_engine #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  function automatic logic [W-1:0] model(input int b, input int e, input int n);
    int r;
    if (n == 0) return '0;
    r = 1 % n;
    for (int i = 0; i < e; i++) r = (r * b) % n;
    return W'(r);
  endfunction

  function automatic int exp_lat(input logic [W-1:0] e, input logic [W-1:0] n);
    if (n == '0) return 1;
`ifdef RSA_MODEXP_SQMUL_EN
    return W + (W + $countones(e)) * (W + 1) + 1;
`else
    return W + int'(e) * (W + 1) + 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one request in IDLE; the following posedge is the accepting edge k.
  task automatic launch(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
    exp_t x;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.base     = b;
    bus.exponent = e;
    bus.modulus  = n;
    x.res = model(int'(b), int'(e), int'(n));
    x.err = (n == '0);
    x.lat = exp_lat(e, n);
    x.bsy = (n != '0);
    sb.push_back(x);
    @(posedge clk);
    k_time = $time;
    #1;
    bus.start    = 1'b0;
    bus.base     = ~b;
    bus.exponent = ~e;
    bus.modulus  = ~n;
    busy_k = bus.busy;
  endtask

  task automatic wait_done(input string tag);
    exp_t x;
    int   lat;
    int   guard;
    x = sb.pop_front();
    guard = 0;
    while (!bus.valid && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    lat = int'(($time - k_time - 1) / PERIOD);
    chk({tag, ".valid"}, 32'(bus.valid), 32'd1);
    chk({tag, ".result"}, 32'(bus.result), 32'(x.res));
    chk({tag, ".error"}, 32'(bus.error), 32'(x.err));
    chk({tag, ".latency"}, 32'(lat), 32'(x.lat));
    chk({tag, ".busy_k1"}, 32'(busy_k), 32'(x.bsy));
    chk({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.start    = 1'b0;
    bus.base     = '0;
    bus.exponent = '0;
    bus.modulus  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.valid", 32'(bus.valid), 32'd0);
    chk("reset.error", 32'(bus.error), 32'd0);
    chk("reset.result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    launch(6'd4, 6'd7, 6'd33);  wait_done("encrypt");
    chk("encrypt.const", 32'(bus.result), 32'd16);
    launch(6'd16, 6'd3, 6'd33); wait_done("decrypt");
    chk("decrypt.const", 32'(bus.result), 32'd4);
    launch(6'd37, 6'd1, 6'd33); wait_done("base_ge_n");
    chk("base_ge_n.const", 32'(bus.result), 32'd4);
    launch(6'd5, 6'd0, 6'd33);  wait_done("exp_zero");
    chk("exp_zero.const", 32'(bus.result), 32'd1);
    launch(6'd5, 6'd4, 6'd1);   wait_done("mod_one");
    chk("mod_one.const", 32'(bus.result), 32'd0);
    launch(6'd9, 6'd0, 6'd1);   wait_done("mod_one_exp_zero");
    launch(6'd9, 6'd3, 6'd0);   wait_done("mod_zero");

    // Start pulse while busy must be dropped.
    launch(6'd4, 6'd7, 6'd33);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base = 6'd2;
    bus.exponent = 6'd5;
    bus.modulus = 6'd33;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("busy_start");
    chk("busy_start.const", 32'(bus.result), 32'd16);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_start.no_rerun_busy", 32'(bus.busy), 32'd0);
    chk("busy_start.valid_held", 32'(bus.valid), 32'd1);
    chk("busy_start.sb_empty", 32'(sb.size()), 32'd0);
    launch(6'd3, 6'd4, 6'd33);  wait_done("after_busy");

    // Reset in the middle of a run.
    launch(6'd4, 6'd7, 6'd33);
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.valid", 32'(bus.valid), 32'd0);
    chk("midrst.error", 32'(bus.error), 32'd0);
    chk("midrst.result", 32'(bus.result), 32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b0;
    launch(6'd2, 6'd5, 6'd33);  wait_done("post_rst");
    chk("post_rst.const", 32'(bus.result), 32'd32);

    for (int i = 0; i < 4; i++) begin
      launch(6'($urandom_range(0, 63)), 6'($urandom_range(0, 9)), 6'($urandom_range(2, 63)));
      wait_done("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
